// File: rtl/i2s_tx_sched_if.sv
// Sample-pair handshake between the synthesiser source and the I2S transmit scheduler.
interface i2s_tx_sched_if #(
    parameter int unsigned WIDTH = 24
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_left;
    logic [WIDTH-1:0] s_right;

    modport master (output s_valid, s_left, s_right, input s_ready);
    modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: NCO-derived MCLK/SCLK/LRCK, one-deep pair buffer, MSB-first I2S serialiser.
// Build option I2S_UNDERRUN_HOLD_EN: an underrun frame repeats the last transferred pair instead of zeros.
module i2s_tx_sched #(
    parameter int unsigned WIDTH    = 24,
    parameter logic [31:0] MCLK_INC = 32'd1055531163
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    i2s_tx_sched_if.slave s,
    output logic          mclk,
    output logic          sclk,
    output logic          lrck,
    output logic          sdata,
    output logic          underrun
);
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             mclk_q, mclk_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [WIDTH-1:0] sr_l_q, sr_l_d, sr_r_q, sr_r_d;
`ifdef I2S_UNDERRUN_HOLD_EN
    logic [WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

    logic [32:0] acc_sum;
    logic [7:0]  bcnt_inc;
    logic        carry, rise, fall_ev, frame_start, accept;
    logic [4:0]  slot;

    assign s.s_ready = en && !rst && !hold_full_q;
    assign accept    = s.s_valid && en && !rst && !hold_full_q;

    always_comb begin
        acc_sum     = {1'b0, acc_q} + {1'b0, MCLK_INC};
        carry       = acc_sum[32];
        rise        = carry && !mclk_q;
        bcnt_inc    = bcnt_q + 8'd1;
        fall_ev     = rise && (bcnt_q[1:0] == 2'b11);
        frame_start = rise && (bcnt_q == 8'hFF);
        slot        = bcnt_inc[6:2];

        state_d     = state_q;
        acc_d       = acc_sum[31:0];
        mclk_d      = mclk_q ^ carry;
        bcnt_d      = rise ? bcnt_inc : bcnt_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
`ifdef I2S_UNDERRUN_HOLD_EN
        last_l_d    = last_l_q;
        last_r_d    = last_r_q;
`endif

        case (state_q)
            ST_OFF:   state_d = ST_PRIME;
            ST_PRIME: if (frame_start) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (fall_ev) begin
            sdata_d = 1'b0;
            if (frame_start) begin
                if (hold_full_q) begin
                    sr_l_d = hold_l_q;
                    sr_r_d = hold_r_q;
`ifdef I2S_UNDERRUN_HOLD_EN
                    last_l_d = hold_l_q;
                    last_r_d = hold_r_q;
`endif
                end else begin
                    // The priming frame's boundary is never reported as an underrun.
                    underrun_d = (state_q == ST_RUN);
`ifdef I2S_UNDERRUN_HOLD_EN
                    sr_l_d = last_l_q;
                    sr_r_d = last_r_q;
`else
                    sr_l_d = '0;
                    sr_r_d = '0;
`endif
                end
            end else if (slot != 5'd0 && 32'(slot) <= WIDTH) begin
                if (bcnt_inc[7]) {sdata_d, sr_r_d} = {sr_r_q, 1'b0};
                else             {sdata_d, sr_l_d} = {sr_l_q, 1'b0};
            end
        end

        // The frame transfer above used the buffer as it stood before this cycle's acceptance.
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = s.s_left;
            hold_r_d    = s.s_right;
        end else if (frame_start) begin
            hold_full_d = 1'b0;
        end

        if (rst || !en) begin
            state_d     = ST_OFF;
            acc_d       = '0;
            mclk_d      = 1'b0;
            bcnt_d      = '0;
            sdata_d     = 1'b0;
            underrun_d  = 1'b0;
            hold_full_d = 1'b0;
            hold_l_d    = '0;
            hold_r_d    = '0;
            sr_l_d      = '0;
            sr_r_d      = '0;
`ifdef I2S_UNDERRUN_HOLD_EN
            last_l_d    = '0;
            last_r_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        acc_q       <= acc_d;
        mclk_q      <= mclk_d;
        bcnt_q      <= bcnt_d;
        sdata_q     <= sdata_d;
        underrun_q  <= underrun_d;
        hold_full_q <= hold_full_d;
        hold_l_q    <= hold_l_d;
        hold_r_q    <= hold_r_d;
        sr_l_q      <= sr_l_d;
        sr_r_q      <= sr_r_d;
`ifdef I2S_UNDERRUN_HOLD_EN
        last_l_q    <= last_l_d;
        last_r_q    <= last_r_d;
`endif
    end

    assign mclk     = mclk_q;
    assign sclk     = bcnt_q[1];
    assign lrck     = bcnt_q[7];
    assign sdata    = sdata_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_i2s_tx_sched.sv
// Bench for i2s_tx_sched: clocks, slots and words predicted from the enabled-cycle count and a pair scoreboard.
module tb_i2s_tx_sched;
    localparam int          W     = 24;
    localparam logic [31:0] INC   = 32'd1055531163;
    localparam longint      INC_L = 64'd1055531163;

    logic clk = 1'b0;
    logic rst, en;
    logic mclk, sclk, lrck, sdata, underrun;

    i2s_tx_sched_if #(.WIDTH(W)) bus ();

    i2s_tx_sched #(.WIDTH(W), .MCLK_INC(INC)) dut (
        .clk(clk), .rst(rst), .en(en), .s(bus),
        .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdata(sdata), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: n = clk edges since enable; frame words come from a one-deep pair buffer.
    longint n;
    bit primed, m_full, m_under;
    logic [W-1:0] m_hl, m_hr, m_wl, m_wr, m_ll, m_lr;

    int cyc, mclk_rises;
    bit acc_seen, lrck_fell, last_pf;
    logic prev_mclk, prev_sclk, prev_lrck;
    logic [31:0] cap_l, cap_r;
    logic [63:0] frames[$];
    int ur_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d cycle=%0d", name, act, lo, hi, cyc);
        end
    endtask

    function automatic longint rises_of(input longint k);
        return (((k * INC_L) >> 32) + 1) / 2;
    endfunction

    function automatic int bcnt_of(input longint k);
        return int'(rises_of(k) % 256);
    endfunction

    function automatic logic [63:0] pat(input logic [W-1:0] l, input logic [W-1:0] r);
        return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
    endfunction

    function automatic logic [4:0] exp_out();
        longint c;
        int b, sl;
        logic sd;
        c  = (n * INC_L) >> 32;
        b  = bcnt_of(n);
        sl = (b / 4) % 32;
        sd = 1'b0;
        if (sl >= 1 && sl <= W) sd = (b >= 128) ? m_wr[W - sl] : m_wl[W - sl];
        return {c[0], b[1], b[7], sd, m_under};
    endfunction

    task automatic step(input logic r_i, input logic e_i, input logic v_i,
                        input logic [W-1:0] l_i, input logic [W-1:0] rr_i);
        logic exp_rdy;
        logic [4:0] e;
        bit fs, take;
        longint r0, r1;
        rst = r_i; en = e_i;
        bus.s_valid = v_i; bus.s_left = l_i; bus.s_right = rr_i;
        #1;
        exp_rdy = e_i && !r_i && !m_full;
        chk("s_ready", bus.s_ready, exp_rdy);
        acc_seen = v_i && bus.s_ready;
        take = v_i && exp_rdy;
        if (r_i || !e_i) begin
            n = 0; primed = 0; m_full = 0; m_under = 0;
            m_hl = '0; m_hr = '0; m_wl = '0; m_wr = '0; m_ll = '0; m_lr = '0;
        end else begin
            r0 = rises_of(n);
            r1 = rises_of(n + 1);
            fs = (r1 != r0) && (r1 % 256 == 0);
            m_under = 0;
            if (fs) begin
                if (m_full) begin
                    m_wl = m_hl; m_wr = m_hr; m_ll = m_hl; m_lr = m_hr;
                end else begin
                    m_under = primed;
`ifdef I2S_UNDERRUN_HOLD_EN
                    m_wl = m_ll; m_wr = m_lr;
`else
                    m_wl = '0; m_wr = '0;
`endif
                end
                primed = 1;
            end
            if (take) begin
                m_full = 1; m_hl = l_i; m_hr = rr_i;
            end else if (fs) begin
                m_full = 0;
            end
            n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        e = exp_out();
        chk("mclk", mclk, e[4]);
        chk("sclk", sclk, e[3]);
        chk("lrck", lrck, e[2]);
        chk("sdata", sdata, e[1]);
        chk("underrun", underrun, e[0]);
        if (mclk && !prev_mclk) mclk_rises++;
        if (sclk && !prev_sclk) begin
            if (lrck) cap_r = {cap_r[30:0], sdata};
            else      cap_l = {cap_l[30:0], sdata};
        end
        lrck_fell = prev_lrck && !lrck;
        if (lrck_fell) frames.push_back({cap_l, cap_r});
        if (underrun) ur_cyc.push_back(cyc);
        prev_mclk = mclk; prev_sclk = sclk; prev_lrck = lrck;
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int guard;
        bit pf;
        guard = 0; pf = 0; acc_seen = 0;
        while (!acc_seen && guard < 5000) begin
            pf = lrck_fell;
            step(1'b0, 1'b1, 1'b1, l, r);
            guard++;
        end
        last_pf = pf;
        chk("send_accept", acc_seen, 1);
    endtask

    task automatic wait_falls(input int k);
        int seen, guard;
        seen = 0; guard = 0;
        while (seen < k && guard < k * 2200) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            guard++;
            if (lrck_fell) seen++;
        end
        chk("frame_wait", seen, k);
    endtask

    initial begin
        int cyc0, guard;
        logic [W-1:0] a, b;
        n = 0; primed = 0; m_full = 0; m_under = 0;
        m_hl = '0; m_hr = '0; m_wl = '0; m_wr = '0; m_ll = '0; m_lr = '0;
        cyc = 0; mclk_rises = 0; acc_seen = 0; lrck_fell = 0; last_pf = 0;
        prev_mclk = 0; prev_sclk = 0; prev_lrck = 0; cap_l = '0; cap_r = '0;

        repeat (4) step(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rst_mclk", mclk, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_lrck", lrck, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", bus.s_ready, 0);

        // Rate and first-frame serialisation, then random traffic over a 20000-cycle window.
        cyc0 = cyc; mclk_rises = 0; frames.delete(); ur_cyc.delete();
        send(24'hA5A5A5, 24'h5A5A5A);
        wait_falls(1);
        chk("prime_no_underrun", ur_cyc.size(), 0);
        while (cyc - cyc0 < 20000) begin
            step(1'b0, 1'b1, ($urandom_range(3) == 0), W'($urandom), W'($urandom));
        end
        chk_range("mclk_rate", mclk_rises, 2457, 2458);
        chk("frames_seen", frames.size() >= 2, 1);
        chk("frame0_zero", (frames.size() >= 1) ? frames[0] : 64'hX, 64'd0);
        chk("frame1_word", (frames.size() >= 2) ? frames[1] : 64'hX, 64'h52D2D280_2D2D2D00);

        // Back-pressure: P1 only enters the buffer right after the wrap that launches P0.
        send(24'h123456, 24'h654321);
        send(24'hABCDEF, 24'hFEDCBA);
        chk("bp_after_wrap", last_pf, 1);
        frames.delete(); ur_cyc.delete();
        wait_falls(5);
        chk("bp_p0", (frames.size() >= 1) ? frames[0] : 64'hX, pat(24'h123456, 24'h654321));
        chk("bp_p1", (frames.size() >= 2) ? frames[1] : 64'hX, pat(24'hABCDEF, 24'hFEDCBA));
`ifdef I2S_UNDERRUN_HOLD_EN
        chk("ur_word", (frames.size() >= 3) ? frames[2] : 64'hX, pat(24'hABCDEF, 24'hFEDCBA));
`else
        chk("ur_word", (frames.size() >= 3) ? frames[2] : 64'hX, 64'd0);
`endif
        chk("ur_count", ur_cyc.size(), 4);
        for (int i = 1; i < ur_cyc.size(); i++)
            chk_range("ur_period", ur_cyc[i] - ur_cyc[i-1], 2083, 2084);

        // Stop at bcnt=100, then restart through the priming frame.
        guard = 0;
        while (bcnt_of(n) != 100 && guard < 3000) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            guard++;
        end
        chk("reach_bcnt100", bcnt_of(n), 100);
        step(1'b0, 1'b0, 1'b1, 24'h111111, 24'h222222);
        chk("stop_mclk", mclk, 0);
        chk("stop_sclk", sclk, 0);
        chk("stop_lrck", lrck, 0);
        chk("stop_sdata", sdata, 0);
        chk("stop_ready", bus.s_ready, 0);
        frames.delete(); ur_cyc.delete();
        a = 24'h0F1E2D; b = 24'h3C4B5A;
        send(a, b);
        wait_falls(1);
        chk("restart_no_underrun", ur_cyc.size(), 0);
        send(24'h777777, 24'h888888);
        wait_falls(1);
        chk("restart_no_underrun2", ur_cyc.size(), 0);
        chk("restart_frame0", (frames.size() >= 1) ? frames[0] : 64'hX, 64'd0);
        chk("restart_frame1", (frames.size() >= 2) ? frames[1] : 64'hX, pat(a, b));

        // Reset during slot 10 with a full buffer.
        wait_falls(1);
        send(24'hC0FFEE, 24'hBADF00);
        guard = 0;
        while (((bcnt_of(n) / 4) % 32) != 10 && guard < 3000) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            guard++;
        end
        chk("slot10_full", bus.s_ready, 0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        chk("mrst_mclk", mclk, 0);
        chk("mrst_sclk", sclk, 0);
        chk("mrst_lrck", lrck, 0);
        chk("mrst_sdata", sdata, 0);
        rst = 1'b0;
        #1;
        chk("mrst_buf_empty", bus.s_ready, 1);
        frames.delete(); ur_cyc.delete();
        send(24'hA5A5A5, 24'h5A5A5A);
        wait_falls(1);
        chk("resume_no_underrun", ur_cyc.size(), 0);
        wait_falls(1);
        chk("resume_frame0", (frames.size() >= 1) ? frames[0] : 64'hX, 64'd0);
        chk("resume_frame1", (frames.size() >= 2) ? frames[1] : 64'hX, 64'h52D2D280_2D2D2D00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/i2s_tx_sched.md
Name: i2s_tx_sched

Overview:
Audio-output controller for the codec path. It derives MCLK, SCLK and LRCK from the 100 MHz system clock and schedules stereo sample delivery through a one-deep holding buffer with a valid/ready handshake. It serialises each sample pair in I2S format on SDATA. It sits between the synthesiser sample source and the DAC pins.

Parameters:
WIDTH, 24, sample width per channel in bits; legal range 1..31.
MCLK_INC, 1055531163, 32-bit NCO increment; MCLK frequency = MCLK_INC * f_clk / 2^33 (12.288 MHz at 100 MHz).

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low stops and flushes the block
s_valid  in  1  sample pair valid
s_ready  out  1  holding buffer can accept a pair
s_left  in  WIDTH  left sample, two's complement
s_right  in  WIDTH  right sample, two's complement
mclk  out  1  master clock to the DAC
sclk  out  1  bit clock, mclk/4 (64 fs)
lrck  out  1  word clock, fs = mclk/256; low = left
sdata  out  1  serial data
underrun  out  1  one-clk pulse when a frame starts with an empty buffer

Behaviour:
- Reset is synchronous, active-high, on clk. While rst or !en:
  - acc = 0, mclk = 0, bcnt = 0, sdata = 0, underrun = 0.
  - Shift registers are zeroed and the holding buffer is emptied.
  - State = OFF.
- s_ready = en && !rst && !hold_full. It is combinational and reads 0 during reset.
- NCO:
  - While en, acc <= acc + MCLK_INC, using 32-bit wrap.
  - A carry-out toggles mclk on the next clk.
- Bit counter:
  - bcnt is 8 bits and increments on every mclk 0->1 transition; it wraps from 255 to 0.
  - sclk = bcnt[1], lrck = bcnt[7]. Both are registered outputs and have no combinational path from acc.
- Slots:
  - A falling-SCLK event is an increment where bcnt[1:0] == 3.
  - After the increment, slot = bcnt[6:2] (0..31) and half = bcnt[7].
- SDATA is updated only on falling-SCLK events:
  - Slot 0: sdata = 0 (I2S one-bit delay).
  - Slot s in 1..WIDTH: sdata = bit WIDTH-s of the current word (left when half = 0, right when half = 1). The MSB goes first.
  - Slots above WIDTH: sdata = 0.
- Handshake:
  - A pair is accepted when s_valid && s_ready in a clk cycle.
  - The holding buffer becomes full on the next clk.
  - s_valid may rise or fall freely; samples are not captured while s_ready is low.
- Frame start is the bcnt 255->0 increment.
  - In RUN with the buffer full: the pair is transferred to the shift registers and the buffer empties in the same clk, so s_ready rises the next cycle.
  - In RUN with the buffer empty: the word is 0 (see the optional feature) and underrun pulses high for exactly 1 clk.
  - If acceptance and frame start fall in the same clk: the incoming pair goes to the holding buffer. The transfer uses the buffer contents from before that clk, so the frame underruns if the buffer was empty.
- State machine:
  - OFF: en=1 -> PRIME, counters start from 0.
  - PRIME: outputs frame 0 as all zeros and suppresses underrun. The holding buffer may fill. First frame start -> RUN, with a normal transfer.
  - RUN: stays in RUN; en=0 -> OFF.
  - From any state: rst -> OFF.
  - en=0 mid-frame takes effect at the next clk edge. All outputs are 0 on the following cycle and a partial word is discarded.
- Latency:
  - The first accepted pair appears at the first frame start after acceptance.
  - The left MSB appears at the first falling-SCLK event after that frame start, i.e. the slot-1 edge.

Optional Feature:
I2S_UNDERRUN_HOLD_EN:
- Defined: on underrun, the shift registers reload the last transferred pair (repeat sample); the underrun pulse still fires. "Last pair" is cleared to 0 by rst or en=0.
- Undefined: on underrun, the word is all zeros.

Test Plan:
1. MCLK rate: rst for 4 cycles, then en=1; count mclk rises over 100000 clk -> 12288 ±1. Every SCLK period = 4 MCLK and every LRCK period = 256 MCLK, exactly.
2. Serialisation: in PRIME, present s_left=24'hA5A5A5, s_right=24'h5A5A5A. Sample sdata on sclk rising -> frame 0 all zeros; frame 1 slot 0 = 0, slots 1..24 = A5A5A5 MSB-first, slots 25..31 = 0; right half = 5A5A5A; no underrun.
3. Back-pressure: hold s_valid=1 with pairs P0 and P1 -> P0 accepted; s_ready low until the next frame start; P1 accepted 1 clk after that wrap; P0 then P1 appear in consecutive frames.
4. Underrun: in RUN with no s_valid -> exactly one 1-clk underrun pulse per LRCK period. sdata is all zeros, or the last pair repeated when I2S_UNDERRUN_HOLD_EN is defined.
5. Mid-frame stop: drop en at bcnt=100 -> next cycle mclk=sclk=lrck=sdata=0 and s_ready=0. Re-enable -> PRIME, with a zero frame first and no underrun.
6. Reset mid-operation: assert rst for 1 clk during slot 10 with the buffer full -> all outputs 0, buffer empty, state OFF. The first frame after resume matches scenario 2.
